// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e      - common 3-bit FSM encoding (IDLE..CLEANUP)
//   UART_DATA_BITS    - payload bits per frame
//   uart_clks_per_bit - clocks per bit from CLK_FREQ / BAUD_RATE
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

  // Integer division; the caller is expected to keep the result in 8..65535.
  function automatic int unsigned uart_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: input conditioning for the UART receiver.
//   clk, rst : system clock, synchronous active-high reset
//   rx       : asynchronous serial line (idles high)
//   rx_s2    : second synchroniser stage, used for edge/level decisions
//   rx_smp   : value used when sampling a bit
// Build option UART_RX_MAJORITY_EN: rx_smp is the 2-of-3 majority of rx_s2
// over the current and two preceding edges; otherwise rx_smp is rx_s2.
// All flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s2,
  output logic rx_smp
);

  logic rx_s1_q, rx_s1_d;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is the second synchroniser stage itself; [1] and [2] are the
  // values rx_s2 held one and two edges earlier.
  logic [2:0] hist_q, hist_d;

  always_comb begin
    rx_s1_d = rx;
    hist_d  = {hist_q[1:0], rx_s1_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      rx_s1_q <= rx_s1_d;
      hist_q  <= hist_d;
    end
  end

  assign rx_s2  = hist_q[0];
  assign rx_smp = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
`else
  logic rx_s2_q, rx_s2_d;

  always_comb begin
    rx_s1_d = rx;
    rx_s2_d = rx_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
    end
  end

  assign rx_s2  = rx_s2_q;
  assign rx_smp = rx_s2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling.
//   clk, rst     : system clock, synchronous active-high reset
//   rx           : asynchronous serial input, idles high
//   rx_data      : last good byte (LSB first on the wire), held between bytes
//   rx_valid     : one-cycle pulse when rx_data is updated
//   rx_frame_err : one-cycle pulse when the stop bit is sampled low
//   rx_busy      : high whenever the FSM is not IDLE
// Parameters CLK_FREQ / BAUD_RATE give T = CLK_FREQ/BAUD_RATE clocks per bit.
// Build option UART_RX_MAJORITY_EN selects 2-of-3 majority sampling (see
// uart_rx_sync); sample-edge timing is the same either way.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_frame_err,
  output logic                      rx_busy
);

  localparam int unsigned T_CLKS   = uart_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF     = T_CLKS / 2;
  localparam logic [15:0] T_M1     = 16'(T_CLKS - 1);
  localparam logic [15:0] HALF_M1  = 16'(HALF - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rx_s2, rx_smp;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_s2  (rx_s2),
    .rx_smp (rx_smp)
  );

  uart_state_e               state_q,     state_d;
  logic [15:0]               clk_count_q, clk_count_d;
  logic [2:0]                bit_index_q, bit_index_d;
  logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
  logic [UART_DATA_BITS-1:0] data_q,      data_d;
  logic                      valid_q,     valid_d;
  logic                      ferr_q,      ferr_d;

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rx_s2) state_d = ST_START;
      end

      // Re-check the start bit at its middle; a high line means a glitch.
      ST_START: begin
        if (clk_count_q == HALF_M1) begin
          clk_count_d = '0;
          state_d     = rx_smp ? ST_IDLE : ST_DATA;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      // Counting a full T from mid-start lands every sample at mid-bit.
      ST_DATA: begin
        if (clk_count_q == T_M1) begin
          clk_count_d = '0;
          shift_d     = {rx_smp, shift_q[UART_DATA_BITS-1:1]};
          if (bit_index_q == LAST_BIT) state_d = ST_STOP;
          else                         bit_index_d = bit_index_q + 3'd1;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      ST_STOP: begin
        if (clk_count_q == T_M1) begin
          clk_count_d = '0;
          state_d     = ST_CLEANUP;
          if (rx_smp) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      // Wait for an idle line so a break or a low line after a framing
      // error is not taken as the next start bit.
      ST_CLEANUP: begin
        if (rx_s2) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx (T=10, HALF=5).
// A line waveform (one bit per clock) is built per segment; a reference model
// reads it using the receiver's timing rules (start found on the synchronised
// line, samples at fixed offsets, cleanup until the line is high) and queues
// the expected pulses and per-cycle busy level. A monitor pops and compares.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int T         = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = T / 2;
  localparam int NCYC      = 8192;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t        exp_q[$];
  bit         wq[$];
  bit         exp_busy [0:NCYC-1];
  bit         chk_busy = 1'b0;
  logic [7:0] model_last = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- waveform builders ----------------
  task automatic add_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) wq.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop_v, input int stop_len);
    add_bits(1'b0, T);
    for (int i = 0; i < 8; i++) add_bits(b[i], T);
    add_bits(stop_v, stop_len);
  endtask

  // ---------------- reference model ----------------
  // Index i of wq is the level the DUT's input flop captures on edge base+i;
  // the synchronised line seen on edge k is therefore wq[k-base-2].
  function automatic bit w_at(input int i);
    if (i < 0 || i >= wq.size()) return 1'b1;
    return wq[i];
  endfunction

  function automatic bit smp_at(input int i);
    if (MAJ) return (w_at(i) & w_at(i-1)) | (w_at(i) & w_at(i-2)) | (w_at(i-1) & w_at(i-2));
    return w_at(i);
  endfunction

  task automatic mark_busy(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (k >= 0 && k < NCYC) exp_busy[k] = 1'b1;
  endtask

  task automatic model_segment(input int b);
    int         n, e, c, s_edge;
    logic [7:0] d;
    bit         stop;
    n = 0;
    while (n < wq.size()) begin
      if (wq[n]) begin
        n++;
      end else begin
        e = n;
        if (smp_at(e + HALF)) begin
          // glitch: busy from start detection until the mid-start check
          mark_busy(b + e + 2, b + e + 1 + HALF);
          n = e + HALF + 1;
        end else begin
          for (int i = 0; i < 8; i++) d[i] = smp_at(e + HALF + T * (i + 1));
          stop   = smp_at(e + HALF + 9 * T);
          s_edge = b + e + 2 + HALF + 9 * T;
          if (stop) begin
            model_last = d;
            exp_q.push_back('{ferr: 1'b0, data: d, at: s_edge});
          end else begin
            exp_q.push_back('{ferr: 1'b1, data: model_last, at: s_edge});
          end
          c = e + HALF + 9 * T + 1;
          while (!w_at(c)) c++;
          mark_busy(b + e + 2, b + c + 1);
          n = c + 1;
        end
      end
    end
  endtask

  task automatic play(input bit use_model);
    @(negedge clk);
    if (use_model) model_segment(cyc + 1);
    for (int j = 0; j < wq.size(); j++) begin
      rx = wq[j];
      @(negedge clk);
    end
    rx = 1'b1;
    wq.delete();
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    ev_t ev;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (rx_valid || rx_frame_err) begin
        check("pulse_exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=0x%02h at cycle %0d, required none",
                   rx_valid, rx_frame_err, rx_data, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_is_ferr", 32'(rx_frame_err), 32'(ev.ferr));
          check("pulse_cycle", cyc, ev.at);
          check("pulse_data", 32'(rx_data), 32'(ev.data));
        end
      end
      if (chk_busy && cyc < NCYC) check("busy", 32'(rx_busy), 32'(exp_busy[cyc]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int f, idx, gap;
    logic [7:0] rb;
    bit sv;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  32'(rx_data),      32'h00);
    check("reset_valid", 32'(rx_valid),     32'd0);
    check("reset_ferr",  32'(rx_frame_err), 32'd0);
    check("reset_busy",  32'(rx_busy),      32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_busy = 1'b1;

    // good frame
    add_bits(1'b1, 5); add_frame(8'hA5, 1'b1, T); add_bits(1'b1, 2 * T);
    play(1'b1);
    check("a5_data", 32'(rx_data), 32'hA5);

    // short low glitch on an idle line
    add_bits(1'b1, 5); add_bits(1'b0, 3); add_bits(1'b1, 2 * T);
    play(1'b1);

    // stop bit low and line held low 30 more cycles
    add_bits(1'b1, 5); add_frame(8'h3C, 1'b0, T + 30); add_bits(1'b1, 2 * T);
    play(1'b1);
    check("ferr_data_held", 32'(rx_data), 32'hA5);

    // back-to-back frames
    add_bits(1'b1, 5);
    add_frame(8'h00, 1'b1, T); add_frame(8'hFF, 1'b1, T); add_frame(8'h55, 1'b1, T);
    add_bits(1'b1, 2 * T);
    play(1'b1);
    check("b2b_last_data", 32'(rx_data), 32'h55);

    // reset during data bit 4 of 0x81; line released with the reset
    chk_busy = 1'b0;
    add_bits(1'b1, 5); add_frame(8'h81, 1'b1, T);
    while (wq.size() > 5 + 5 * T + HALF) void'(wq.pop_back());
    play(1'b0);
    check("busy_mid_frame", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 8'h00;
    check("midrst_data",  32'(rx_data),      32'h00);
    check("midrst_valid", 32'(rx_valid),     32'd0);
    check("midrst_busy",  32'(rx_busy),      32'd0);
    repeat (3) @(negedge clk);
    chk_busy = 1'b1;
    add_bits(1'b1, 5); add_frame(8'h42, 1'b1, T); add_bits(1'b1, 2 * T);
    play(1'b1);
    check("after_rst_data", 32'(rx_data), 32'h42);

    // one-cycle inversions aligned to each data-bit sample edge
    add_bits(1'b1, 5);
    f = wq.size();
    add_frame(8'h96, 1'b1, T);
    for (int i = 0; i < 8; i++) begin
      idx = f + HALF + T * (i + 1);
      wq[idx] = ~wq[idx];
    end
    add_bits(1'b1, 2 * T);
    play(1'b1);
    check("spike_data", 32'(rx_data), MAJ ? 32'h96 : 32'h69);

    // random frames, gaps, stop errors and glitches
    add_bits(1'b1, 5);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        add_bits(1'b0, $urandom_range(1, 4));
        add_bits(1'b1, 8);
      end
      rb  = 8'($urandom);
      sv  = ($urandom_range(0, 3) != 0);
      add_frame(rb, sv, sv ? T : T + int'($urandom_range(0, 15)));
      gap = $urandom_range(0, 8);
      add_bits(1'b1, sv ? gap : gap + 1);
    end
    add_bits(1'b1, 2 * T);
    play(1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
